fp_classify_stream: RTL
=======================

// Module: fp_classify_stream
//
// PURPOSE
//   Pipelined, multi-lane IEEE-754 classifier with a valid/ready stream interface.
//   Each accepted beat carries LANES packed operands. The block returns a 10-bit
//   one-hot class vector per lane, one cycle later, through a backpressurable output register.
//   It also accumulates per-class saturating event counters and a sticky sNaN flag,
//   for use by FPU exception and statistics logic.
//
// PARAMETERS
//   WIDTH  16  operand width; legal values 16, 32, 64 (others: elaboration error)
//   LANES  4   operands per beat, >=1
//   CNT_W  16  width of each per-class event counter, >=2
//
// PORTS
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              input beat valid
//   in_ready   out  1              input beat accepted when in_valid&&in_ready
//   in_data    in   LANES*WIDTH    lane k = in_data[k*WIDTH +: WIDTH]
//   out_valid  out  1              output beat valid
//   out_ready  in   1              downstream accepts when out_valid&&out_ready
//   out_class  out  LANES*10       lane k one-hot = out_class[k*10 +: 10]
//   stat_clr   in   1              synchronous clear of counters and sticky flag
//   stat_cnt   out  10*CNT_W       counter for class c = stat_cnt[c*CNT_W +: CNT_W]
//   snan_seen  out  1              sticky: an sNaN was accepted since reset/clear
//
// BEHAVIOUR
//   Class bit order (fclass order):
//     0 -inf, 1 -normal, 2 -denormal, 3 -0, 4 +0, 5 +denormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN
//   - NaN: exp all-ones, mant!=0. The mantissa MSB set gives qNaN, else sNaN; NaN sign is ignored.
//   - Exactly one bit is set per lane for every input pattern.
//   - Reset: out_valid=0, out_class=0, all stat_cnt=0, snan_seen=0. in_ready is combinational and reads 1 after reset.
//   - Latency: 1 cycle. An accepted beat appears on out_class in the next cycle with out_valid=1.
//   - in_ready = !out_valid || out_ready (single register stage; no skid, no bubble).
//   - The output register loads on accept. Otherwise out_valid drops on out_ready, else it holds.
//     out_class is stable while out_valid && !out_ready.
//   - Full throughput is 1 beat/cycle with out_ready held high.
//   - in_data is ignored when no accept occurs; out_class is don't-care while out_valid=0.
//   - Counters update on input accept, not on output handshake.
//     cnt[c] += popcount of lane bit c across LANES (0..LANES added per cycle).
//   - Saturation: if cnt[c]+inc > 2^CNT_W-1, cnt[c] = 2^CNT_W-1 and holds until clear; no wrap.
//   - stat_clr with no accept: all counters go to 0 and snan_seen goes to 0.
//   - stat_clr with a same-cycle accept: clear wins over the old value. cnt[c] = inc of this beat (saturated),
//     and snan_seen = (this beat has an sNaN).
//   - snan_seen sets on accept of any lane with class bit 8.
//   - stat_clr does not affect the stream path.
//   - Reset mid-transfer: the in-flight beat is dropped, out_valid=0 immediately (async). No partial counts remain.
//   - No other state machine exists: the stream state is out_valid only (EMPTY/FULL).
//
// STRUCTURE
//   - Shared include fp_class_defs.vh:
//       class index localparams (FPC_NEG_INF..FPC_QNAN, FPC_NUM=10)
//       EXP_W mapping for 16/32/64 (5/8/11), MANT_W = WIDTH-1-EXP_W
//   - Sub-module fp_class_lane (combinational): WIDTH in, 10-bit one-hot out; instanced LANES times via generate.
//   - Top level holds the output register, handshake, per-class popcount-adder, saturating counters and sticky flag.
//
// TESTING  (WIDTH=16, LANES=4, CNT_W=4 unless stated)
//   1. lanes {7C00,7E00,7C01,8001} -> next cycle out_class lanes = {bit7,bit9,bit8,bit2};
//      cnt[7]=cnt[9]=cnt[8]=cnt[2]=1, snan_seen=1
//   2. lanes {8000,0000,3C00,BC00} -> {bit3,bit4,bit6,bit1}; each one-hot, others 0
//   3. out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after first accept,
//      out_class frozen, counters count one beat only; release -> 1 beat/cycle streaming
//   4. 5 beats of 4x 3C00 (20 +normal events) -> cnt[6]=15 saturated; other counters 0
//   5. stat_clr in same cycle as accept of 4x 7C01 -> cnt[8]=4, all others 0, snan_seen=1
//   6. rst_n low while out_valid=1 -> out_valid=0, counters 0 asynchronously;
//      WIDTH=32/64 rerun of case 1 with 7F800000/7FC00000 and 64-bit equivalents

Source files
------------

// File: rtl/fp_classify_stream_pkg.sv
// rtl/fp_classify_stream_pkg.sv - class indices and format helpers shared by the classifier
package fp_classify_stream_pkg;

  localparam int FPC_NEG_INF  = 0;
  localparam int FPC_NEG_NORM = 1;
  localparam int FPC_NEG_DEN  = 2;
  localparam int FPC_NEG_ZERO = 3;
  localparam int FPC_POS_ZERO = 4;
  localparam int FPC_POS_DEN  = 5;
  localparam int FPC_POS_NORM = 6;
  localparam int FPC_POS_INF  = 7;
  localparam int FPC_SNAN     = 8;
  localparam int FPC_QNAN     = 9;
  localparam int FPC_NUM      = 10;

  // Exponent field width for the supported IEEE-754 binary formats; 0 marks an unsupported width.
  function automatic int exp_width(input int width);
    case (width)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fp_classify_stream_lane.sv
// rtl/fp_classify_stream_lane.sv - combinational one-hot classifier for a single operand
module fp_class_lane
  import fp_classify_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   data,
  output logic [FPC_NUM-1:0] cls
);

  localparam int EXP_W  = exp_width(WIDTH);
  localparam int MANT_W = WIDTH - 1 - EXP_W;

  logic              sign;
  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant;

  assign sign  = data[WIDTH-1];
  assign exp_f = data[WIDTH-2 -: EXP_W];
  assign mant  = data[MANT_W-1:0];

  always_comb begin
    cls = '0;
    if (&exp_f) begin
      if (mant == '0) begin
        cls[sign ? FPC_NEG_INF : FPC_POS_INF] = 1'b1;
      end else begin
        // NaN sign is deliberately ignored; only the quiet bit matters.
        cls[mant[MANT_W-1] ? FPC_QNAN : FPC_SNAN] = 1'b1;
      end
    end else if (exp_f == '0) begin
      if (mant == '0) begin
        cls[sign ? FPC_NEG_ZERO : FPC_POS_ZERO] = 1'b1;
      end else begin
        cls[sign ? FPC_NEG_DEN : FPC_POS_DEN] = 1'b1;
      end
    end else begin
      cls[sign ? FPC_NEG_NORM : FPC_POS_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_classify_stream.sv
// rtl/fp_classify_stream.sv - multi-lane IEEE-754 classifier stream with saturating class statistics
module fp_classify_stream
  import fp_classify_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*FPC_NUM-1:0]   out_class,
  input  logic                       stat_clr,
  output logic [FPC_NUM*CNT_W-1:0]   stat_cnt,
  output logic                       snan_seen
);

  localparam int INC_W = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  if (WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("fp_classify_stream: WIDTH must be 16, 32 or 64");
  end

  logic                       accept;
  logic [FPC_NUM-1:0]         lane_cls [LANES];
  logic [LANES*FPC_NUM-1:0]   class_next;
  logic [INC_W-1:0]           inc      [FPC_NUM];
  logic [SUM_W-1:0]           sum      [FPC_NUM];
  logic [CNT_W-1:0]           cnt_next [FPC_NUM];
  logic [CNT_W-1:0]           cnt      [FPC_NUM];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp_class_lane #(.WIDTH(WIDTH)) u_lane (
      .data (in_data[k*WIDTH +: WIDTH]),
      .cls  (lane_cls[k])
    );
    assign class_next[k*FPC_NUM +: FPC_NUM] = lane_cls[k];
  end

  // A clear in the same cycle as an accept discards the old count before adding this beat.
  always_comb begin
    for (int c = 0; c < FPC_NUM; c++) begin
      inc[c] = '0;
      for (int k = 0; k < LANES; k++) begin
        inc[c] = inc[c] + INC_W'(lane_cls[k][c]);
      end
      sum[c]      = (stat_clr ? '0 : SUM_W'(cnt[c])) + SUM_W'(inc[c]);
      cnt_next[c] = (sum[c] > CNT_MAX) ? {CNT_W{1'b1}} : sum[c][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_class <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_class <= class_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < FPC_NUM; c++) cnt[c] <= '0;
      snan_seen <= 1'b0;
    end else if (accept) begin
      for (int c = 0; c < FPC_NUM; c++) cnt[c] <= cnt_next[c];
      snan_seen <= (snan_seen && !stat_clr) || (inc[FPC_SNAN] != '0);
    end else if (stat_clr) begin
      for (int c = 0; c < FPC_NUM; c++) cnt[c] <= '0;
      snan_seen <= 1'b0;
    end
  end

  for (genvar c = 0; c < FPC_NUM; c++) begin : g_cnt_out
    assign stat_cnt[c*CNT_W +: CNT_W] = cnt[c];
  end

endmodule
